// File: rtl/nco_clk_gen_if.sv
// nco_clk_gen_if: runtime configuration port of the NCO clock generator.
interface nco_clk_gen_if #(
    parameter int ACC_W = 32,
    parameter int CH_W  = 1
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_ftw;
    logic             cfg_phase_rst;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_ftw, cfg_phase_rst,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_ftw, cfg_phase_rst,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/nco_clk_gen.sv
// nco_clk_gen: NUM_CH phase-accumulator clock outputs with runtime-tunable rates.
module nco_clk_gen #(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 32,
    parameter int                      CH_W        = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1,
    parameter int                      LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] FTW_INIT    = {32'd85899346, 32'd343597384}
) (
    input  logic               refclk,
    input  logic               rst,
    nco_clk_gen_if.slave       cfg,
    output logic [NUM_CH-1:0]  outclk_o,
    output logic [NUM_CH-1:0]  tick_o,
    output logic               locked_o
);
    localparam int               CNT_W    = ($clog2(LOCK_CYCLES) > 0) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_W-1:0] FTW_MAX  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(NUM_CH);

    typedef enum logic {SETTLE, IDLE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [ACC_W-1:0]   acc_q [NUM_CH];
    logic [ACC_W-1:0]   acc_d [NUM_CH];
    logic [ACC_W-1:0]   ftw_q [NUM_CH];
    logic [ACC_W-1:0]   ftw_d [NUM_CH];
    logic [NUM_CH-1:0]  tick_q, tick_d;
    logic [ACC_W:0]     sum;
    logic               req_ok, accept, phase_clr;

    always_comb begin
        req_ok    = ({1'b0, cfg.cfg_ch} < CH_LIM) && (cfg.cfg_ftw <= FTW_MAX);
        accept    = (state_q == IDLE) && cfg.cfg_valid && req_ok;
        phase_clr = accept && cfg.cfg_phase_rst;
        state_d   = state_q;
        cnt_d     = cnt_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        if (state_q == SETTLE) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d  = IDLE;
                cnt_d    = cnt_q;
                locked_d = 1'b1;
            end
        end else if (cfg.cfg_valid) begin
            if (req_ok) begin
                state_d  = SETTLE;
                cnt_d    = CNT_INIT;
                locked_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // The tuning word written on the accept edge only affects additions after it.
    always_comb begin
        sum    = '0;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum       = {1'b0, acc_q[i]} + {1'b0, ftw_q[i]};
            acc_d[i]  = phase_clr ? '0 : sum[ACC_W-1:0];
            tick_d[i] = phase_clr ? 1'b0 : sum[ACC_W];
            ftw_d[i]  = (accept && cfg.cfg_ch == CH_W'(i)) ? cfg.cfg_ftw : ftw_q[i];
            outclk_o[i] = acc_q[i][ACC_W-1];
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q  <= SETTLE;
            cnt_q    <= CNT_INIT;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            tick_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                ftw_q[i] <= FTW_INIT[i*ACC_W +: ACC_W];
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            tick_q   <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                ftw_q[i] <= ftw_d[i];
            end
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign cfg.cfg_err   = err_q;
    assign tick_o        = tick_q;
    assign locked_o      = locked_q;
endmodule

// File: tb/tb_nco_clk_gen.sv
// tb_nco_clk_gen: directed checks of reset, lock timing, rates and config handling.
module tb_nco_clk_gen;
    logic       refclk = 1'b0;
    logic       rst    = 1'b0;
    logic [1:0] outclk, tick;
    logic       locked;
    int         errors = 0;
    int         checks = 0;

    nco_clk_gen_if #(.ACC_W(32), .CH_W(2)) cfg_if ();

    nco_clk_gen #(.NUM_CH(2), .ACC_W(32), .CH_W(2), .LOCK_CYCLES(16)) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg      (cfg_if),
        .outclk_o (outclk),
        .tick_o   (tick),
        .locked_o (locked)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic count_ticks(input int n, output int t0, output int t1);
        t0 = 0;
        t1 = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            t0 += int'(tick[0]);
            t1 += int'(tick[1]);
        end
    endtask

    task automatic send(input logic [1:0] ch, input logic [31:0] ftw, input logic prst);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_ch        = ch;
        cfg_if.cfg_ftw       = ftw;
        cfg_if.cfg_phase_rst = prst;
        step(1);
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_phase_rst = 1'b0;
    endtask

    initial begin
        int t0, t1, c0, c1, bad0, bad1, last0, last1;
        logic p0, p1, hold0, moved0;
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_ch        = '0;
        cfg_if.cfg_ftw       = '0;
        cfg_if.cfg_phase_rst = 1'b0;

        // 1: reset and lock timing
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("rst_outclk", outclk, 0);
            chk("rst_tick", tick, 0);
            chk("rst_ready", cfg_if.cfg_ready, 0);
            chk("rst_locked", locked, 0);
        end
        rst = 1'b1;
        step(15);
        chk("lock_e15", locked, 0);
        chk("ready_e15", cfg_if.cfg_ready, 0);
        step(1);
        chk("lock_e16", locked, 1);
        chk("ready_e16", cfg_if.cfg_ready, 1);

        // 2: default rates and periods
        c0 = 0; c1 = 0; bad0 = 0; bad1 = 0; last0 = -1; last1 = -1;
        p0 = outclk[0]; p1 = outclk[1];
        for (int k = 0; k < 25000; k++) begin
            step(1);
            c0 += int'(tick[0]);
            c1 += int'(tick[1]);
            if (outclk[0] && !p0) begin
                if (last0 >= 0 && (k - last0) != 12 && (k - last0) != 13) bad0++;
                last0 = k;
            end
            if (outclk[1] && !p1) begin
                if (last1 >= 0 && (k - last1) != 50) bad1++;
                last1 = k;
            end
            p0 = outclk[0];
            p1 = outclk[1];
        end
        chk("tick0_cnt", (c0 >= 1999 && c0 <= 2001) ? 2000 : c0, 2000);
        chk("tick1_cnt", (c1 >= 499 && c1 <= 501) ? 500 : c1, 500);
        chk("ch0_period", bad0, 0);
        chk("ch1_period", bad1, 0);

        // 3: ch1 quarter rate with phase align
        send(2'd1, 32'h4000_0000, 1'b1);
        chk("align_outclk", outclk, 0);
        chk("align_tick", tick, 0);
        chk("align_locked", locked, 0);
        chk("align_ready", cfg_if.cfg_ready, 0);
        step(3);
        chk("q_tick1_e3", tick[1], 0);
        step(1);
        chk("q_tick1_e4", tick[1], 1);
        step(4);
        chk("q_tick1_e8", tick[1], 1);
        step(7);
        chk("q_lock_e15", locked, 0);
        step(1);
        chk("q_lock_e16", locked, 1);
        chk("q_tick1_e16", tick[1], 1);

        // 4: rejected requests
        send(2'd2, 32'h1000_0000, 1'b0);
        chk("err_ch", cfg_if.cfg_err, 1);
        chk("err_ch_locked", locked, 1);
        chk("err_ch_ready", cfg_if.cfg_ready, 1);
        step(1);
        chk("err_ch_end", cfg_if.cfg_err, 0);
        send(2'd0, 32'h8000_0001, 1'b0);
        chk("err_ftw", cfg_if.cfg_err, 1);
        chk("err_ftw_locked", locked, 1);
        step(1);
        chk("err_ftw_end", cfg_if.cfg_err, 0);
        count_ticks(250, t0, t1);
        chk("err_rate0", (t0 >= 19 && t0 <= 21) ? 20 : t0, 20);
        chk("err_rate1", t1, 62);
        chk("err_locked_after", locked, 1);

        // 5: freeze ch0
        send(2'd0, 32'h0, 1'b0);
        step(1);
        hold0 = outclk[0];
        moved0 = 1'b0;
        c0 = 0; c1 = 0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            c0 += int'(tick[0]);
            c1 += int'(tick[1]);
            if (outclk[0] !== hold0) moved0 = 1'b1;
        end
        chk("frz_outclk0", moved0, 0);
        chk("frz_tick0", c0, 0);
        chk("frz_tick1", c1, 10);
        chk("frz_locked", locked, 1);

        // 6: reset in the middle of SETTLE
        send(2'd0, 32'h2000_0000, 1'b0);
        step(4);
        chk("mid_locked", locked, 0);
        rst = 1'b0;
        step(1);
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_outclk", outclk, 0);
        chk("mid_rst_ready", cfg_if.cfg_ready, 0);
        rst = 1'b1;
        step(15);
        chk("mid_lock_e15", locked, 0);
        step(1);
        chk("mid_lock_e16", locked, 1);
        count_ticks(250, t0, t1);
        chk("mid_rate0", (t0 >= 19 && t0 <= 21) ? 20 : t0, 20);
        chk("mid_rate1", (t1 >= 4 && t1 <= 6) ? 5 : t1, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
